// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared mode codes, state encoding and default width for the serial tx slice
package usr_pkg;

    localparam int DEF_DATA_WIDTH = 4;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/usr_serial_tx_ctrl_if.sv
// rtl/usr_serial_tx_ctrl_if.sv - word/serial handshakes plus shift register control bundle
interface usr_serial_tx_ctrl_if import usr_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SEL_WIDTH  = 2
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_msb_first;
    logic                  s_fill;
    logic [DATA_WIDTH-1:0] q_in;
    logic [SEL_WIDTH-1:0]  sel_mux;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  sr;
    logic                  sl;
    logic                  ser_out;
    logic                  ser_valid;
    logic                  ser_ready;
    logic                  busy;
    logic                  done;

    modport slave (
        input  s_valid, s_data, s_msb_first, s_fill, q_in, ser_ready,
        output s_ready, sel_mux, in_data, sr, sl, ser_out, ser_valid, busy, done
    );

    modport master (
        output s_valid, s_data, s_msb_first, s_fill, q_in, ser_ready,
        input  s_ready, sel_mux, in_data, sr, sl, ser_out, ser_valid, busy, done
    );

endinterface

// File: rtl/universal_Shift_reg_top.sv
// rtl/universal_Shift_reg_top.sv - 4-bit universal shift register: hold, shift right/left, parallel load
module universal_Shift_reg_top import usr_pkg::*; #(
    parameter int WIDTH = DEF_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [1:0]       sel_mux,
    input  logic [WIDTH-1:0] in,
    input  logic             sr,
    input  logic             sl,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_q <= '0;
        end else begin
            case (sel_mux)
                SEL_SHR:  r_q <= {sr, r_q[WIDTH-1:1]};
                SEL_SHL:  r_q <= {r_q[WIDTH-2:0], sl};
                SEL_LOAD: r_q <= in;
                default:  r_q <= r_q;
            endcase
        end
    end

    assign q_out = r_q;

endmodule

// File: rtl/usr_serial_tx_ctrl.sv
// rtl/usr_serial_tx_ctrl.sv - loads words into the universal shift register and streams them out serially
module usr_serial_tx_ctrl import usr_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SEL_WIDTH  = 2,
    parameter int CNT_WIDTH  = 3
) (
    input  logic              i_clk,
    input  logic              clr,
    usr_serial_tx_ctrl_if.slave bus
);

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_word;
    logic                  r_msb;
    logic                  r_fill;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic                  w_accept;
    logic                  w_shift;
    logic                  w_last;
    logic [SEL_WIDTH-1:0]  w_sel;
    logic [DATA_WIDTH-1:0] w_in_data;
    logic                  w_sr;
    logic                  w_sl;

    assign w_accept = (r_state == ST_IDLE) && bus.s_valid;
    assign w_shift  = (r_state == ST_SHIFT) && bus.ser_ready;
    assign w_last   = (r_cnt == CNT_WIDTH'(DATA_WIDTH - 1));

    always_ff @(posedge i_clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Direction and fill are frozen at capture so mid-word input changes cannot corrupt the stream.
    always_ff @(posedge i_clk or negedge clr) begin
        if (!clr) begin
            r_word <= '0;
            r_msb  <= 1'b0;
            r_fill <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_word <= bus.s_data;
            r_msb  <= bus.s_msb_first;
            r_fill <= bus.s_fill;
            r_cnt  <= '0;
        end else if (w_shift) begin
            r_cnt  <= r_cnt + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.s_valid) w_next = ST_LOAD;
            ST_LOAD:  w_next = ST_SHIFT;
            ST_SHIFT: if (bus.ser_ready && w_last) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_sel     = SEL_WIDTH'(SEL_HOLD);
        w_in_data = '0;
        w_sr      = 1'b0;
        w_sl      = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_sel     = SEL_WIDTH'(SEL_LOAD);
                w_in_data = r_word;
            end
            ST_SHIFT: begin
                if (bus.ser_ready) begin
                    w_sel = r_msb ? SEL_WIDTH'(SEL_SHL) : SEL_WIDTH'(SEL_SHR);
                    w_sr  = r_msb ? 1'b0 : r_fill;
                    w_sl  = r_msb ? r_fill : 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign bus.sel_mux   = w_sel;
    assign bus.in_data   = w_in_data;
    assign bus.sr        = w_sr;
    assign bus.sl        = w_sl;
    assign bus.s_ready   = (r_state == ST_IDLE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.ser_valid = (r_state == ST_SHIFT);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.ser_out   = r_msb ? bus.q_in[DATA_WIDTH-1] : bus.q_in[0];

endmodule
